q_cycle_sequencer: RTL
======================

// Module: q_cycle_sequencer
// PURPOSE
//  Generates the four-phase Q1..Q4 instruction-cycle timing that drives fetchState/executeState for the PC,
//  IR and ALU. Tracks pipeline validity: the execute slot becomes a forced-NOP bubble after skip/goto
//  flushes and on pipeline priming. Also sequences power-up hold, SLEEP entry and wake-up.
// PARAMETERS
//  RESET_HOLD_CYCLES  4  clocks held idle after rst before first fetch (1..255)
//  WAKE_CYCLES        8  clocks of oscillator start-up between wake_req and resuming RUN (1..255)
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst         in   1  synchronous reset, active high
//  skip        in   1  from PC: skip pending (set at EX Q4, cleared by PC at EX Q1)
//  goto        in   1  from PC: control transfer pending (same timing as skip)
//  sleep_req   in   1  SLEEP instruction executing; sampled at Q4 only
//  wake_req    in   1  WDT time-out / wake-on-change; level, sampled every clock
//  q_phase     out  2  current phase: 0=Q1 1=Q2 2=Q3 3=Q4; fetch and execute share it
//  fe_en       out  1  fetch stage active (PC increments at FE Q1 only when 1)
//  ex_valid    out  1  execute slot holds a real instruction; 0 = decode as NOP
//  ir_load     out  1  one-clock pulse at fetch Q4: latch program word into IR
//  retire      out  1  one-clock pulse at Q4 when ex_valid=1
//  sleeping    out  1  core in SLEEP or WAKE state
// BEHAVIOUR
//  Reset values: q_phase=0, fe_en=0, ex_valid=0, ir_load=0, retire=0, sleeping=0, state=HOLD, counters=0.
//  rst overrides all inputs; asserting it mid-cycle or mid-SLEEP returns to HOLD on the next edge.
//  FSM states: HOLD, RUN, SLEEP, WAKE (2-bit encoding, internal).
//   HOLD : 8-bit counter increments each clock; q_phase=0; all outputs 0. When count==RESET_HOLD_CYCLES-1,
//          go to RUN at Q1 with primed=0.
//   RUN  : q_phase advances 0->1->2->3->0 each clock. fe_en=1. ir_load=1 when q_phase==3.
//   SLEEP: q_phase frozen at 0; fe_en=ex_valid=ir_load=retire=0; sleeping=1. wake_req=1 -> WAKE.
//   WAKE : counter runs as in HOLD, up to WAKE_CYCLES-1; sleeping=1; then RUN at Q1 with primed=1.
//          The instruction prefetched before SLEEP executes first.
//  Pipeline validity:
//   - primed flag: cleared on HOLD exit; set at the Q4 of the first RUN cycle.
//   - During Q1, ex_valid is combinational = primed & ~(skip|goto).
//     skip/goto are registered by the PC at the Q4 edge and are visible during Q1.
//   - At the Q1->Q2 edge this value is latched into bubble_n; ex_valid=bubble_n during Q2..Q4.
//     A flushed cycle therefore stays a bubble even after the PC clears skip/goto in Q1.
//   - retire = (q_phase==3) & ex_valid.
//  Sleep entry: at Q4 with ex_valid=1 and sleep_req=1:
//   - wake_req=0 -> next state SLEEP, q_phase=0.
//   - wake_req=1 on the same clock -> SLEEP executes as NOP; stay in RUN.
//   - sleep_req with ex_valid=0, or in Q1..Q3, is ignored.
//  skip/goto outside Q1 affect nothing; skip and goto together = one bubble.
//  Consecutive flushes (goto in a cycle that follows a bubble) are impossible by construction;
//  the bubble cycle cannot assert skip/goto.
//  Latency: first ir_load occurs RESET_HOLD_CYCLES+3 clocks after rst deasserts.
//  First retire occurs RESET_HOLD_CYCLES+7 clocks after rst deasserts.
// TESTING
//  - Power-up: RESET_HOLD_CYCLES=4, rst 1->0 -> outputs 0 for 4 clocks; q_phase 0,1,2,3; ir_load on clock 7;
//    ex_valid=0 first cycle; retire first at clock 11.
//  - Goto flush: skip/goto=1 during Q1 of cycle N -> ex_valid=0 for all of Q1..Q4 of N even after the PC
//    clears them at Q1; retire absent; cycle N+1 valid.
//  - Sleep/wake: sleep_req at valid Q4 -> sleeping=1, q_phase=0, fe_en=0. wake_req=1 -> 8 clocks of WAKE,
//    then RUN Q1 with ex_valid=1.
//  - Sleep-as-NOP: sleep_req and wake_req both 1 at Q4 -> stays RUN; sleeping never 1; next Q1 follows.
//  - Ignored sleep: sleep_req=1 during Q2, or at Q4 of a bubble cycle -> no state change.
//  - Reset mid-op: rst=1 during WAKE count=3 and during RUN Q2 -> next clock HOLD, all outputs at reset values.

Source files
------------

// File: rtl/q_cycle_if.sv
// ----------------------------------------------------------------------------
// q_cycle_if : PC/pipeline-side signal bundle of the Q1..Q4 cycle sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface q_cycle_if;
  logic       skip;
  logic       goto;
  logic       sleep_req;
  logic       wake_req;
  logic [1:0] q_phase;
  logic       fe_en;
  logic       ex_valid;
  logic       ir_load;
  logic       retire;
  logic       sleeping;

  modport master (
    input  skip, goto, sleep_req, wake_req,
    output q_phase, fe_en, ex_valid, ir_load, retire, sleeping
  );

  modport slave (
    output skip, goto, sleep_req, wake_req,
    input  q_phase, fe_en, ex_valid, ir_load, retire, sleeping
  );
endinterface

`default_nettype wire

// File: rtl/q_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// q_cycle_sequencer : Q1..Q4 instruction-cycle timing, pipeline validity,
//                     power-up hold and SLEEP/wake sequencing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module q_cycle_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES       = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  q_cycle_if.master bus
);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SLEEP = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  localparam logic [7:0] C_HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);
  localparam logic [7:0] C_WAKE_LAST = 8'(WAKE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       primed_q, primed_d;
  logic       bubble_n_q, bubble_n_d;

  logic       w_ex_valid;
  logic       w_fe_en;
  logic       w_ir_load;
  logic       w_retire;
  logic       w_sleeping;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      phase_q    <= 2'd0;
      cnt_q      <= 8'd0;
      primed_q   <= 1'b0;
      bubble_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      bubble_n_q <= bubble_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    bubble_n_d = bubble_n_q;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == C_HOLD_LAST) begin
          state_d  = ST_RUN;
          cnt_d    = 8'd0;
          phase_d  = 2'd0;
          primed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        phase_d = phase_q + 2'd1;
        // Freeze the Q1 verdict so a flush survives the PC clearing skip/goto.
        if (phase_q == 2'd0) begin
          bubble_n_d = w_ex_valid;
        end
        if (phase_q == 2'd3) begin
          primed_d = 1'b1;
          if (w_ex_valid && bus.sleep_req && !bus.wake_req) begin
            state_d = ST_SLEEP;
            phase_d = 2'd0;
          end
        end
      end
      ST_SLEEP: begin
        phase_d = 2'd0;
        cnt_d   = 8'd0;
        if (bus.wake_req) begin
          state_d = ST_WAKE;
        end
      end
      default: begin
        // Instruction prefetched before SLEEP is still in IR, so resume primed.
        if (cnt_q == C_WAKE_LAST) begin
          state_d  = ST_RUN;
          cnt_d    = 8'd0;
          phase_d  = 2'd0;
          primed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    w_ex_valid = 1'b0;
    w_fe_en    = 1'b0;
    w_ir_load  = 1'b0;
    w_retire   = 1'b0;
    w_sleeping = (state_q == ST_SLEEP) || (state_q == ST_WAKE);
    if (state_q == ST_RUN) begin
      w_fe_en    = 1'b1;
      w_ex_valid = (phase_q == 2'd0) ? (primed_q & ~(bus.skip | bus.goto)) : bubble_n_q;
      w_ir_load  = (phase_q == 2'd3);
      w_retire   = (phase_q == 2'd3) & w_ex_valid;
    end
  end

  assign bus.q_phase  = phase_q;
  assign bus.fe_en    = w_fe_en;
  assign bus.ex_valid = w_ex_valid;
  assign bus.ir_load  = w_ir_load;
  assign bus.retire   = w_retire;
  assign bus.sleeping = w_sleeping;

endmodule

`default_nettype wire
